// File: rtl/me_mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory-access controller: request
// codes, UART register addresses, FSM states and status-word layout.
package me_mem_access_ctrl_pkg;

  // MEM-stage request codes; 2'b11 is decoded as no request.
  localparam logic [1:0] MEM_CTL_NONE  = 2'b00;
  localparam logic [1:0] MEM_CTL_READ  = 2'b10;
  localparam logic [1:0] MEM_CTL_WRITE = 2'b01;

  // Default memory-mapped UART register addresses.
  localparam logic [15:0] UART_DATA_ADDR_DFLT = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DFLT = 16'hBF01;

  // Bit positions inside the UART status word.
  localparam int STAT_WRITE_READY_BIT = 0;
  localparam int STAT_DATA_READY_BIT  = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_URD_0,
    ST_URD_1,
    ST_UWR_0,
    ST_UWR_1
  } state_e;

  // Status word: data-ready flag and "transmitter fully empty" flag.
  function automatic logic [15:0] uart_status_word(input logic data_ready,
                                                   input logic tbre,
                                                   input logic tsre);
    logic [15:0] w;
    w = '0;
    w[STAT_DATA_READY_BIT]  = data_ready;
    w[STAT_WRITE_READY_BIT] = tbre & tsre;
    return w;
  endfunction

endpackage

// File: rtl/me_mem_access_ctrl.sv
// Memory-access stage controller: owns the shared SRAM bus and the UART.
// Fetches instructions for IF while idle, runs multi-cycle load/store
// sequences for MEM and stalls the pipeline while a sequence is in flight.
module me_mem_access_ctrl
  import me_mem_access_ctrl_pkg::*;
#(
  parameter int          RAM_ADDR_W     = 18,
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DFLT,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            MeMemControl,
  input  logic [15:0]           MeAddr,
  input  logic [15:0]           MeWriteData,
  input  logic [15:0]           IfPc,
  output logic [15:0]           memDataRead,
  output logic [15:0]           ifInstruction,
  output logic                  stall,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  inout  wire logic [15:0]      ram_data,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic                  uart_rdn,
  output logic                  uart_wrn,
  input  logic                  uart_data_ready,
  input  logic                  uart_tbre,
  input  logic                  uart_tsre
);

  state_e      state_q, state_d;
  logic [15:0] mem_data_read_q, mem_data_read_d;
  logic [15:0] if_instruction_q, if_instruction_d;
  logic        data_drive;

  logic me_rd, me_wr, is_uart_data, is_uart_stat, multi_cycle_req;

  assign me_rd           = (MeMemControl == MEM_CTL_READ);
  assign me_wr           = (MeMemControl == MEM_CTL_WRITE);
  assign is_uart_data    = (MeAddr == UART_DATA_ADDR);
  assign is_uart_stat    = (MeAddr == UART_STAT_ADDR);
  // Status reads finish in IDLE and status writes are dropped; nothing else
  // can complete without leaving IDLE.
  assign multi_cycle_req = (me_rd || me_wr) && !is_uart_stat;

  // Only write sequences own the data bus; the SRAM or UART drive it otherwise.
  assign ram_data = data_drive ? MeWriteData : 16'hzzzz;

  assign memDataRead   = mem_data_read_q;
  assign ifInstruction = if_instruction_q;

  // State and result registers.
  // NOTE: sequential state uses non-blocking assignments only; every next
  // value is computed in always_comb so each flop has exactly one writer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      mem_data_read_q  <= '0;
      if_instruction_q <= '0;
    end else begin
      state_q          <= state_d;
      mem_data_read_q  <= mem_data_read_d;
      if_instruction_q <= if_instruction_d;
    end
  end

  // Next-state decode: IDLE dispatches, every sequence walks back to IDLE.
  // NOTE: defaults are assigned first so no path leaves a variable unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (me_rd && is_uart_data)       state_d = ST_URD_0;
        else if (me_rd && !is_uart_stat) state_d = ST_RD;
        else if (me_wr && is_uart_data)  state_d = ST_UWR_0;
        else if (me_wr && !is_uart_stat) state_d = ST_WR_SETUP;
      end
      ST_RD:       state_d = ST_IDLE;
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: state_d = ST_WR_HOLD;
      ST_WR_HOLD:  state_d = ST_IDLE;
      ST_URD_0:    state_d = ST_URD_1;
      ST_URD_1:    state_d = ST_IDLE;
      ST_UWR_0:    state_d = ST_UWR_1;
      ST_UWR_1:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Result capture: fetch on every IDLE edge, loads at the end of a read.
  always_comb begin
    mem_data_read_d  = mem_data_read_q;
    if_instruction_d = if_instruction_q;
    unique case (state_q)
      ST_IDLE: begin
        if_instruction_d = ram_data;
        if (me_rd && is_uart_stat)
          mem_data_read_d = uart_status_word(uart_data_ready, uart_tbre, uart_tsre);
      end
      ST_RD, ST_URD_1: mem_data_read_d = ram_data;
      default: ;
    endcase
  end

  // Bus strobes, address, data-drive enable and stall per state.
  always_comb begin
    ram_ce_n   = 1'b1;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    uart_rdn   = 1'b1;
    uart_wrn   = 1'b1;
    data_drive = 1'b0;
    stall      = 1'b0;
    ram_addr   = {{(RAM_ADDR_W-16){1'b0}}, MeAddr};
    unique case (state_q)
      ST_IDLE: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_addr = {{(RAM_ADDR_W-16){1'b0}}, IfPc};
        stall    = multi_cycle_req;
      end
      ST_RD: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
      end
      ST_WR_SETUP: begin
        ram_ce_n   = 1'b0;
        data_drive = 1'b1;
        stall      = 1'b1;
      end
      ST_WR_PULSE: begin
        ram_ce_n   = 1'b0;
        ram_we_n   = 1'b0;
        data_drive = 1'b1;
        stall      = 1'b1;
      end
      ST_WR_HOLD: begin
        ram_ce_n   = 1'b0;
        data_drive = 1'b1;
      end
      ST_URD_0: begin
        uart_rdn = 1'b0;
        stall    = 1'b1;
      end
      ST_URD_1: uart_rdn = 1'b0;
      ST_UWR_0: begin
        uart_wrn   = 1'b0;
        data_drive = 1'b1;
        stall      = 1'b1;
      end
      ST_UWR_1: data_drive = 1'b1;
      default: ;
    endcase
    // Reset also forces the bus quiet here, because the reset state (IDLE)
    // would otherwise start a fetch while rst is still low.
    if (!rst) begin
      ram_ce_n   = 1'b1;
      ram_oe_n   = 1'b1;
      ram_we_n   = 1'b1;
      uart_rdn   = 1'b1;
      uart_wrn   = 1'b1;
      data_drive = 1'b0;
      stall      = 1'b0;
      ram_addr   = '0;
    end
  end

endmodule

// File: tb/tb_me_mem_access_ctrl.sv
// Self-checking bench for me_mem_access_ctrl: SRAM and UART behavioural
// models on the shared bus, transaction-level reference model, directed
// cases followed by randomized requests.
module tb_me_mem_access_ctrl;
  import me_mem_access_ctrl_pkg::*;

  localparam logic [15:0] PROBE = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  MeMemControl = MEM_CTL_NONE;
  logic [15:0] MeAddr = '0, MeWriteData = '0, IfPc = '0;
  logic [15:0] memDataRead, ifInstruction;
  logic        stall;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Environment: SRAM contents, UART receive byte, captured UART transmits.
  logic [15:0] sram    [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] ref_mdr = '0;
  logic [15:0] uart_rx = '0;
  logic [15:0] uart_tx_seen = '0;
  int          uart_tx_count = 0;
  logic        probe_drv = 1'b0;

  wire sram_drv = !ram_ce_n && !ram_oe_n && ram_we_n;
  wire uart_drv = !uart_rdn;
  assign ram_data = sram_drv  ? sram[ram_addr[9:0]] :
                    uart_drv  ? uart_rx :
                    probe_drv ? PROBE : 16'hzzzz;

  always @(posedge ram_we_n) if (!ram_ce_n) sram[ram_addr[9:0]] = ram_data;
  always @(posedge uart_wrn) begin
    uart_tx_seen  = ram_data;
    uart_tx_count = uart_tx_count + 1;
  end

  always #5 clk = ~clk;

  me_mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .MeMemControl(MeMemControl), .MeAddr(MeAddr), .MeWriteData(MeWriteData), .IfPc(IfPc),
    .memDataRead(memDataRead), .ifInstruction(ifInstruction), .stall(stall),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    if (obs !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Quiet-bus reset state.
  task automatic check_reset_state(input string pfx);
    probe_drv = 1'b1;
    #1;
    check({pfx, "_bus_hiz"}, ram_data, PROBE);
    check({pfx, "_strobes"}, {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
    check({pfx, "_addr"}, ram_addr, 0);
    check({pfx, "_mdr"}, memDataRead, 0);
    check({pfx, "_ifi"}, ifInstruction, 0);
    probe_drv = 1'b0;
  endtask

  // Apply one request just after a posedge, watch it to completion and
  // compare against the transaction-level expectations.
  task automatic run_op(input logic [1:0] ctl, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] pc);
    bit is_rd, is_wr, done;
    int exp_stall, exp_we, exp_rdn, exp_wrn, exp_tx;
    int n_stall, n_we, n_rdn, n_wrn, n_bad, tx_before;
    logic [15:0] exp_if;
    is_rd = (ctl == 2'b10);
    is_wr = (ctl == 2'b01);
    exp_stall = 0; exp_we = 0; exp_rdn = 0; exp_wrn = 0; exp_tx = 0;
    n_stall = 0; n_we = 0; n_rdn = 0; n_wrn = 0; n_bad = 0; done = 0;
    exp_if    = ref_mem[pc[9:0]];
    tx_before = uart_tx_count;
    MeMemControl = ctl; MeAddr = addr; MeWriteData = wd; IfPc = pc;

    if (is_rd && addr == 16'hBF00) begin
      exp_stall = 2; exp_rdn = 2; ref_mdr = uart_rx;
    end else if (is_rd && addr == 16'hBF01) begin
      ref_mdr = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
    end else if (is_rd) begin
      exp_stall = 1; ref_mdr = ref_mem[addr[9:0]];
    end else if (is_wr && addr == 16'hBF00) begin
      exp_stall = 2; exp_wrn = 1; exp_tx = 1;
    end else if (is_wr && addr != 16'hBF01) begin
      exp_stall = 3; exp_we = 1; ref_mem[addr[9:0]] = wd;
    end

    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (!ram_we_n) n_we++;
      if (!uart_rdn) n_rdn++;
      if (!uart_wrn) n_wrn++;
      if (!ram_oe_n && !ram_we_n) n_bad++;
      if (!ram_ce_n && (!uart_rdn || !uart_wrn)) n_bad++;
      if (stall) n_stall++; else done = 1;
      @(posedge clk);
    end
    #1;
    check("op_timeout", {31'b0, done}, 1);
    check("stall_cycles", n_stall, exp_stall);
    check("we_low_cycles", n_we, exp_we);
    check("rdn_low_cycles", n_rdn, exp_rdn);
    check("wrn_low_cycles", n_wrn, exp_wrn);
    check("bus_rule", n_bad, 0);
    check("mem_data_read", memDataRead, ref_mdr);
    check("if_instruction", ifInstruction, exp_if);
    if (exp_tx != 0) begin
      check("uart_tx_count", uart_tx_count - tx_before, 1);
      check("uart_tx_data", uart_tx_seen, wd);
    end
    MeMemControl = MEM_CTL_NONE;
  endtask

  initial begin
    logic [15:0] a, d, pc;
    logic [1:0]  ctl;
    int          r;

    for (int i = 0; i < 1024; i++) begin
      d = 16'($urandom);
      sram[i] = d;
      ref_mem[i] = d;
    end
    sram[4]      = 16'h6A01; ref_mem[4]      = 16'h6A01;
    sram[16'h100] = 16'hBEEF; ref_mem[16'h100] = 16'hBEEF;
    sram[16'h300] = 16'h1234; ref_mem[16'h300] = 16'h1234;

    // Power-on reset.
    repeat (2) @(posedge clk);
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    run_op(MEM_CTL_NONE, 16'h0000, 16'h0000, 16'h0004);
    run_op(MEM_CTL_READ, 16'h0100, 16'h0000, 16'h0004);
    run_op(MEM_CTL_NONE, 16'h0100, 16'h0000, 16'h0005);
    run_op(2'b11,        16'h0200, 16'h5555, 16'h0006);
    run_op(MEM_CTL_WRITE, 16'h0200, 16'h1234, 16'h0007);
    run_op(MEM_CTL_READ,  16'h0200, 16'h0000, 16'h0008);
    uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
    run_op(MEM_CTL_READ,  16'hBF01, 16'h0000, 16'h0009);
    run_op(MEM_CTL_WRITE, 16'hBF01, 16'hFFFF, 16'h000A);
    uart_rx = 16'h0041;
    run_op(MEM_CTL_READ,  16'hBF00, 16'h0000, 16'h000B);
    run_op(MEM_CTL_WRITE, 16'hBF00, 16'h0042, 16'h000C);

    // Randomized requests.
    for (int k = 0; k < 250; k++) begin
      ctl = 2'($urandom);
      r   = $urandom_range(0, 99);
      a   = (r < 20) ? 16'hBF00 : (r < 32) ? 16'hBF01 : 16'($urandom_range(0, 1023));
      d   = 16'($urandom);
      pc  = 16'($urandom_range(0, 1023));
      uart_rx = 16'($urandom);
      uart_data_ready = 1'($urandom); uart_tbre = 1'($urandom); uart_tsre = 1'($urandom);
      run_op(ctl, a, d, pc);
    end

    // Reset in the middle of the write strobe.
    MeMemControl = MEM_CTL_WRITE; MeAddr = 16'h0300; MeWriteData = 16'h1234; IfPc = 16'h0004;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pulse_before_reset", ram_we_n, 0);
    rst = 1'b0;
    check_reset_state("mid_wr");
    ref_mdr = '0;
    MeMemControl = MEM_CTL_NONE;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(MEM_CTL_READ, 16'h0300, 16'h0000, 16'h0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
